// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle WIDTH-bit add/subtract, SLICE bits per cycle with a registered inter-slice carry.
// Valid/ready on both sides; flags (carry, overflow, negative, zero) match a single-cycle adder.
module addsub_seq #(
   parameter int WIDTH = 64,
   parameter int SLICE = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             negative,
   output logic             zero
);
   localparam int N  = WIDTH / SLICE;
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, res_q, res_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             sub_q, sub_d, carry_q, carry_d, nz_q, nz_d;
   logic             co_q, co_d, ov_q, ov_d, ng_q, ng_d, zr_q, zr_d;
   logic [SLICE-1:0] a_k, b_k;
   logic [SLICE:0]   sum;
   logic             c_msb, last;

   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign result    = res_q;
   assign carry_out = co_q;
   assign overflow  = ov_q;
   assign negative  = ng_q;
   assign zero      = zr_q;
   assign last      = cnt_q == LAST;

   // One slice of the ripple; carry into the slice MSB is recovered from the sum bit.
   always_comb begin
      a_k   = a_q[cnt_q*SLICE +: SLICE];
      b_k   = b_q[cnt_q*SLICE +: SLICE] ^ {SLICE{sub_q}};
      sum   = {1'b0, a_k} + {1'b0, b_k} + {{SLICE{1'b0}}, carry_q};
      c_msb = a_k[SLICE-1] ^ b_k[SLICE-1] ^ sum[SLICE-1];
      acc_d = acc_q;
      if (state_q == RUN)
         acc_d[cnt_q*SLICE +: SLICE] = sum[SLICE-1:0];
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      nz_d    = nz_q;
      res_d   = res_q;
      co_d    = co_q;
      ov_d    = ov_q;
      ng_d    = ng_q;
      zr_d    = zr_q;
      if (state_q == IDLE && in_valid) begin
         a_d     = a;
         b_d     = b;
         sub_d   = sub;
         carry_d = sub;
         cnt_d   = '0;
         nz_d    = 1'b0;
         state_d = RUN;
      end else if (state_q == RUN) begin
         carry_d = sum[SLICE];
         nz_d    = nz_q | (|sum[SLICE-1:0]);
         cnt_d   = last ? '0 : cnt_q + 1'b1;
         if (last) begin
            state_d = DONE;
            res_d   = acc_d;
            co_d    = sum[SLICE];
            ov_d    = c_msb ^ sum[SLICE];
            ng_d    = sum[SLICE-1];
            zr_d    = ~nz_d;
         end
      end else if (state_q == DONE) begin
         state_d = out_ready ? IDLE : DONE;
      end else if (state_q != IDLE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         sub_q   <= 1'b0;
         carry_q <= 1'b0;
         nz_q    <= 1'b0;
         co_q    <= 1'b0;
         ov_q    <= 1'b0;
         ng_q    <= 1'b0;
         zr_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         sub_q   <= sub_d;
         carry_q <= carry_d;
         nz_q    <= nz_d;
         co_q    <= co_d;
         ov_q    <= ov_d;
         ng_q    <= ng_d;
         zr_q    <= zr_d;
      end
   end
endmodule

// File: tb/tb_addsub_seq.sv
// tb_addsub_seq: directed and random checks of addsub_seq built with SLICE = 16, 8 and 64 side by side.
module tb_addsub_seq;
   logic clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b0;
   logic [63:0] a = '0, b = '0;
   logic [2:0] ir, ov, co, of, ng, zr;
   logic [2:0][63:0] res;
   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : u
      addsub_seq #(.WIDTH(64), .SLICE(g == 0 ? 16 : g == 1 ? 8 : 64)) dut (
         .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(ir[g]), .sub(sub),
         .a(a), .b(b), .out_valid(ov[g]), .out_ready(out_ready), .result(res[g]),
         .carry_out(co[g]), .overflow(of[g]), .negative(ng[g]), .zero(zr[g]));
   end

   function automatic int ns(input int g);
      return g == 0 ? 4 : g == 1 ? 8 : 1;
   endfunction

   // Single-cycle reference: returns {carry_out, overflow, result}.
   function automatic logic [65:0] model(input logic s, input logic [63:0] x, input logic [63:0] y);
      logic [63:0] yx;
      logic [64:0] t;
      yx = s ? ~y : y;
      t  = {1'b0, x} + {1'b0, yx} + {64'd0, s};
      return {t[64], (x[63] == yx[63]) && (t[63] != x[63]), t[63:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ef = {carry_out, overflow, negative, zero}
   task automatic op(input string tag, input logic s, input logic [63:0] x, input logic [63:0] y,
                     input int stall, input logic [63:0] er, input logic [3:0] ef);
      int lat [3];
      lat = '{0, 0, 0};
      for (int k = 0; k < 20 && ir != 3'b111; k++) tick();
      chk({tag, " ready"}, 64'(ir), 64'(3'b111));
      in_valid = 1'b1; sub = s; a = x; b = y;
      tick();
      a = ~x; b = x ^ y; sub = ~s;
      for (int k = 1; k <= 20 && ov != 3'b111; k++) begin
         tick();
         for (int g = 0; g < 3; g++) if (ov[g] && lat[g] == 0) lat[g] = k;
      end
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("%s/%0d lat", tag, g), 64'(lat[g]), 64'(ns(g)));
         chk($sformatf("%s/%0d res", tag, g), res[g], er);
         chk($sformatf("%s/%0d flags", tag, g), 64'({co[g], of[g], ng[g], zr[g]}), 64'(ef));
      end
      for (int k = 0; k < stall; k++) begin
         tick();
         chk($sformatf("%s stall%0d hs", tag, k), 64'({ov, ir}), 64'(6'b111000));
         chk($sformatf("%s stall%0d res", tag, k), res[0], er);
         chk($sformatf("%s stall%0d flags", tag, k), 64'({co[0], of[0], ng[0], zr[0]}), 64'(ef));
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk({tag, " post hs"}, 64'({ov, ir}), 64'(6'b000111));
      chk({tag, " post res"}, res[0], er);
   endtask

   initial begin
      logic [65:0] m;
      logic [63:0] x, y;
      logic s;
      logic [63:0] sp [4];
      sp = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
      repeat (2) tick();
      chk("rst hs", 64'({ov, ir}), 64'(6'b000111));
      chk("rst res", res[0], 64'd0);
      chk("rst flags", 64'({co[0], of[0], ng[0], zr[0]}), 64'(4'b0001));
      reset_n = 1'b1;
      op("add",    1'b0, 64'd4321, 64'd5678, 0, 64'd9999, 4'b0000);
      op("sl_cy",  1'b0, 64'h0000_0000_0000_FFFF, 64'd1, 0, 64'h0000_0000_0001_0000, 4'b0000);
      op("ovf",    1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 0, 64'h8000_0000_0000_0000, 4'b0110);
      op("sub",    1'b1, 64'd5678, 64'd1234, 0, 64'd4444, 4'b1000);
      op("sub_ov", 1'b1, 64'h8000_0000_0000_0000, 64'd1, 0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b1100);
      op("sub_z",  1'b1, 64'd5, 64'd5, 0, 64'd0, 4'b1001);
      op("sub_n",  1'b1, 64'd0, 64'd1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0010);
      op("bp",     1'b0, 64'd4321, 64'd5678, 5, 64'd9999, 4'b0000);
      in_valid = 1'b1; sub = 1'b0; a = 64'd3; b = 64'd4;
      tick();
      in_valid = 1'b0;
      tick();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("mid rst hs", 64'({ov, ir}), 64'(6'b000111));
      chk("mid rst zero", 64'(zr), 64'(3'b111));
      chk("mid rst res", res[0], 64'd0);
      op("after rst", 1'b0, 64'd1, 64'd1, 0, 64'd2, 4'b0000);
      for (int i = 0; i < 300; i++) begin
         s = 1'($urandom);
         x = $urandom_range(0, 3) == 0 ? sp[$urandom_range(0, 3)] : {$urandom, $urandom};
         y = $urandom_range(0, 3) == 0 ? sp[$urandom_range(0, 3)] : {$urandom, $urandom};
         m = model(s, x, y);
         op($sformatf("rnd%0d", i), s, x, y, $urandom_range(0, 3), m[63:0],
            {m[65], m[64], m[63], m[63:0] == 64'd0});
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
